// File: rtl/ram.sv
// rtl/ram.sv - byte-addressed little-endian RAM with fixed request latency (optional dump: RAM_DEBUG_DUMP_EN)
module ram #(
    parameter int DEPTH   = 65536,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] adr,
    input  logic        load,
    input  logic [31:0] in,
    input  logic [2:0]  siz,
    input  logic        deb,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // Storage starts zeroed and is deliberately untouched by reset.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    state_t         state_q, state_d;
    logic [3:0]     cnt_q,   cnt_d;
    logic [AW-1:0]  adr_q,   adr_d;
    logic           load_q,  load_d;
    logic [31:0]    in_q,    in_d;
    logic [2:0]     siz_q,   siz_d;
    logic [31:0]    out_q,   out_d;
    logic           done_q,  done_d;

    logic [AW-1:0]  a0, a1, a2, a3;
    logic [31:0]    rd_word;
    logic [31:0]    rd_ext;
    logic           fin;

    // Byte lanes wrap modulo DEPTH because the address math is AW bits wide.
    assign a0 = adr_q;
    assign a1 = adr_q + AW'(1);
    assign a2 = adr_q + AW'(2);
    assign a3 = adr_q + AW'(3);

    assign rd_word = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign fin     = (state_q == S_BUSY) && (cnt_q == 4'd0);

    // Size/sign handling for read data; unlisted size codes behave as a word.
    always_comb begin
        rd_ext = rd_word;
        case (siz_q)
            3'b000:  rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b100:  rd_ext = {24'h0, rd_word[7:0]};
            3'b101:  rd_ext = {16'h0, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    // Request sequencing: accept when idle, count down, complete on the LATENCY-th edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        load_d  = load_q;
        in_d    = in_q;
        siz_d   = siz_q;
        out_d   = out_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    adr_d   = adr[AW-1:0];
                    load_d  = load;
                    in_d    = in;
                    siz_d   = siz;
                    done_d  = 1'b0;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!load_q) begin
                        out_d = rd_ext;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            load_q  <= 1'b0;
            in_q    <= 32'h0;
            siz_q   <= 3'b000;
            out_q   <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            load_q  <= load_d;
            in_q    <= in_d;
            siz_q   <= siz_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Array write commits on the completing edge; only the sized bytes change.
    always_ff @(posedge clk) begin
        if (fin && load_q) begin
            mem[a0] <= in_q[7:0];
            if (siz_q[1:0] != 2'b00) begin
                mem[a1] <= in_q[15:8];
            end
            if (siz_q[1]) begin
                mem[a2] <= in_q[23:16];
                mem[a3] <= in_q[31:24];
            end
        end
    end

    assign out  = out_q;
    assign busy = (state_q == S_BUSY);
    assign done = done_q;

`ifdef RAM_DEBUG_DUMP_EN
    logic deb_q;
    logic unused_ok;
    assign unused_ok = &{1'b0, adr[31:AW]};

    // Dump the first 16 words on a rising edge of deb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb;
            if (deb && !deb_q) begin
                for (int i = 0; i < 16; i++) begin
                    $display("%08h %02h%02h%02h%02h", i * 4,
                             mem[AW'(i * 4 + 3)], mem[AW'(i * 4 + 2)],
                             mem[AW'(i * 4 + 1)], mem[AW'(i * 4)]);
                end
            end
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, deb, adr[31:AW]};
`endif

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - table-driven scoreboard bench for ram
module tb_ram;

    localparam int DEPTH   = 65536;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] adr;
    logic        load;
    logic [31:0] in_d;
    logic [2:0]  siz;
    logic        deb;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_out;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        ld;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    ram #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .adr   (adr),
        .load  (load),
        .in    (in_d),
        .siz   (siz),
        .deb   (deb),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) begin
                tests++;
                fails++;
                $display("FAIL %s busy_mid: got 0 expected 1 at cycle %0d", name, n);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
        end else begin
            check({name, " latency"}, n, LATENCY);
            check({name, " busy_end"}, {31'h0, busy}, 32'h0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s scoreboard: got empty queue expected an entry", name);
            end else begin
                check({name, " out"}, out, exp_q.pop_front());
            end
        end
    endtask

    task automatic run_req(input string name, input logic ld, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] s, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        load  = ld;
        adr   = a;
        in_d  = d;
        siz   = s;
        exp_q.push_back(ld ? last_out : exp);
        if (!ld) last_out = exp;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " busy_acc"}, {31'h0, busy}, 32'h1);
        check({name, " done_acc"}, {31'h0, done}, 32'h0);
        wait_done(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         3'b000, 32'hFFFF_FFDE});
        vecs.push_back('{1'b0, 32'h0000_0013, 32'h0,         3'b100, 32'h0000_00DE});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         3'b001, 32'hFFFF_DEAD});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         3'b101, 32'h0000_DEAD});
        vecs.push_back('{1'b1, 32'h0000_0011, 32'h1234_5677, 3'b000, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         3'b010, 32'hDEAD_77EF});
        vecs.push_back('{1'b1, 32'h0000_0021, 32'h1122_3344, 3'b010, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0024, 32'h0,         3'b000, 32'h0000_0011});
        vecs.push_back('{1'b1, DEPTH - 2,     32'hA1B2_C3D4, 3'b010, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         3'b000, 32'hFFFF_FFB2});
        vecs.push_back('{1'b0, DEPTH - 1,     32'h0,         3'b000, 32'hFFFF_FFC3});
        vecs.push_back('{1'b0, DEPTH - 1,     32'h0,         3'b101, 32'h0000_B2C3});
        vecs.push_back('{1'b0, DEPTH - 2,     32'h0,         3'b010, 32'hA1B2_C3D4});
        vecs.push_back('{1'b0, 32'h0000_0020, 32'h0,         3'b011, 32'h2233_4400});
        vecs.push_back('{1'b1, 32'h0000_0030, 32'hCAFE_8001, 3'b001, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         3'b111, 32'h0000_8001});
        vecs.push_back('{1'b0, 32'h0000_0030, 32'h0,         3'b001, 32'hFFFF_8001});
        vecs.push_back('{1'b0, 32'h1234_0010, 32'h0,         3'b110, 32'hDEAD_77EF});

        rst = 1'b1; start = 1'b1; load = 1'b0; adr = 32'h10; in_d = 32'h0; siz = 3'b010; deb = 1'b0;
        last_out = 32'h0;
        @(posedge clk);
        #1;
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset done", {31'h0, done}, 32'h0);
        check("reset out", out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].ld, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].exp);
        end

        // start held across busy: second address ignored, then back-to-back accept
        @(negedge clk);
        start = 1'b1; load = 1'b0; adr = 32'h10; siz = 3'b010;
        exp_q.push_back(32'hDEAD_77EF);
        @(posedge clk);
        #1;
        check("hold busy_acc", {31'h0, busy}, 32'h1);
        adr = 32'h30; siz = 3'b111;
        wait_done("hold first");
        exp_q.push_back(32'h0000_8001);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b busy_acc", {31'h0, busy}, 32'h1);
        check("b2b done_clr", {31'h0, done}, 32'h0);
        wait_done("b2b second");
        last_out = 32'h0000_8001;

        // reset in the middle of a write to 0x40
        @(negedge clk);
        start = 1'b1; load = 1'b1; adr = 32'h40; in_d = 32'h5566_7788; siz = 3'b010;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort busy_acc", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        start = 1'b1;
        #1;
        check("abort busy", {31'h0, busy}, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        check("abort out", out, 32'h0);
        @(posedge clk);
        #1;
        check("rst start_ignored", {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        last_out = 32'h0;
        run_req("abort readback", 1'b0, 32'h40, 32'h0, 3'b010, 32'h0);

        // deb pulse: ignored in the default build
        @(negedge clk);
        deb = 1'b1;
        @(negedge clk);
        deb = 1'b0;
        @(negedge clk);
        check("deb idle busy", {31'h0, busy}, 32'h0);
        check("scoreboard empty", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DEPTH, default 65536, memory size in bytes (power of two); address bits above log2(DEPTH) ignored, i.e. addresses wrap modulo DEPTH.
REQ-002 Parameter LATENCY, default 2, clock cycles from accepted start to done (valid range 1..15).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request strobe, sampled on rising clk.
REQ-006 adr  input  32  byte address of access.
REQ-007 load  input  1  direction: 0 = read from memory, 1 = write to memory.
REQ-008 in  input  32  write data, low bytes used per size.
REQ-009 siz  input  3  RISC-V funct3 size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-010 out  output  32  read data, extended to 32 bits.
REQ-011 busy  output  1  request in progress.
REQ-012 done  output  1  last request completed.
REQ-013 deb  input  1  debug dump trigger (see Configuration).

Function
REQ-014 Request accepted at rising clk when start=1 and busy=0; adr, load, in, siz latched; busy=1 and done=0 from next cycle.
REQ-015 start while busy=1 ignored; no queueing.
REQ-016 Exactly LATENCY cycles after acceptance: busy=0, done=1, read data on out, write committed to array in that same edge.
REQ-017 done and out hold until next accepted request or reset; back-to-back request accepted in the cycle done first asserts.
REQ-018 Byte addressing, little-endian: byte k of the access at address (adr+k) mod DEPTH; misaligned and wrapping accesses allowed.
REQ-019 Read: siz 000/001 sign-extend byte/half, 100/101 zero-extend, 010 full word.
REQ-020 Write: siz[1:0]=00 writes in[7:0], 01 writes in[15:0], 10 writes in[31:0]; other bytes untouched.
REQ-021 Undefined siz codes (011, 110, 111) treated as word.
REQ-022 Write request leaves out unchanged from previous value.
REQ-023 Array initialised to all zeros at time zero; not cleared by reset.

Reset
REQ-024 While rst=1: busy=0, done=0, out=0, internal counter cleared, start ignored.
REQ-025 Reset during an in-flight request aborts it; a pending write is not committed.
REQ-026 First request accepted at first rising clk with rst=0 and start=1.

Configuration
REQ-027 Macro RAM_DEBUG_DUMP_EN: when defined, a rising edge on deb (sampled on clk) prints one line per word for addresses 0x00..0x3C: address and 32-bit content in hex; when undefined, deb is ignored and no print logic is compiled.

Verification
REQ-028 Reset, then write word adr=0x10 in=0xDEADBEEF, read word 0x10 -> out=0xDEADBEEF exactly LATENCY cycles after accept, busy=1 in between.
REQ-029 After REQ-028, read byte 0x13 siz=000 -> 0xFFFFFFDE; siz=100 -> 0x000000DE; half 0x12 siz=001 -> 0xFFFFDEAD, siz=101 -> 0x0000DEAD.
REQ-030 Write byte 0x11 in=0x12345677 then read word 0x10 -> 0xDEAD77EF; misaligned word write 0x21 in=0x11223344, read byte 0x24 -> 0x00000011.
REQ-031 Wrap: write word adr=DEPTH-2 in=0xA1B2C3D4, read byte 0 -> 0xFFFFFFB2, byte DEPTH-1 -> 0xFFFFFFC3.
REQ-032 start held during busy -> only first request accepted; assert rst mid write to 0x40 -> busy=done=0 immediately, later read of 0x40 returns 0.
REQ-033 With RAM_DEBUG_DUMP_EN defined, deb 0->1 -> 16 dump lines printed; undefined -> none.
